// File: rtl/hazard_controller.sv
// Stall/flush/forward controller for the 5-stage pipeline: post-reset bubbles, load-use,
// taken branch, imem wait watchdog. Define HAZARD_PERF_CNT_EN to build the perf counters.
module hazard_controller #(
  parameter int ADDR_WIDTH    = 5,
  parameter int RESET_BUBBLES = 3,
  parameter int IMEM_TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] Rs1D_i,
  input  logic [ADDR_WIDTH-1:0] Rs2D_i,
  input  logic [ADDR_WIDTH-1:0] Rs1E_i,
  input  logic [ADDR_WIDTH-1:0] Rs2E_i,
  input  logic [ADDR_WIDTH-1:0] RdE_i,
  input  logic [ADDR_WIDTH-1:0] RdM_i,
  input  logic [ADDR_WIDTH-1:0] RdW_i,
  input  logic                  ResultSrcE0_i,
  input  logic                  RegWriteM_i,
  input  logic                  RegWriteW_i,
  input  logic                  PCSrcE_i,
  input  logic                  ImemReady_i,
  output logic                  StallF_o,
  output logic                  StallD_o,
  output logic                  FlushD_o,
  output logic                  FlushE_o,
  output logic [1:0]            ForwardAE_o,
  output logic [1:0]            ForwardBE_o,
  output logic                  ImemErr_o,
  output logic [31:0]           StallCycles_o,
  output logic [31:0]           FlushCount_o
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_IWAIT, S_ERROR} state_t;

  localparam logic [3:0] LAST_BUBBLE = 4'(RESET_BUBBLES - 1);
  localparam logic [7:0] LAST_WAIT   = 8'(IMEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] bubble_q, bubble_d;
  logic [7:0] wait_q, wait_d;
  logic       load_use;
  logic       active;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      bubble_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      bubble_q <= bubble_d;
      wait_q   <= wait_d;
    end
  end

  assign load_use = ResultSrcE0_i && (RdE_i != '0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
  assign active   = (state_q == S_RUN) || (state_q == S_IWAIT);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    bubble_d = bubble_q;
    wait_d   = wait_q;
    unique case (state_q)
      S_INIT: begin
        bubble_d = bubble_q + 4'd1;
        if (bubble_q == LAST_BUBBLE) state_d = S_RUN;
      end
      S_RUN: begin
        if (!ImemReady_i && !PCSrcE_i) begin
          state_d = S_IWAIT;
          wait_d  = 8'd1;
        end
      end
      S_IWAIT: begin
        if (PCSrcE_i) begin
          // A redirect abandons the stalled fetch; the new fetch gets a fresh timeout.
          wait_d  = '0;
          state_d = ImemReady_i ? S_RUN : S_IWAIT;
        end else if (ImemReady_i) begin
          wait_d  = '0;
          state_d = S_RUN;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == LAST_WAIT) state_d = S_ERROR;
        end
      end
      S_ERROR: ;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    unique case (state_q)
      S_RUN, S_IWAIT: begin
        if (PCSrcE_i) begin
          FlushD_o = 1'b1;
          FlushE_o = 1'b1;
        end else if (load_use) begin
          StallF_o = 1'b1;
          StallD_o = 1'b1;
          FlushE_o = 1'b1;
        end else if (!ImemReady_i) begin
          StallF_o = 1'b1;
          FlushD_o = 1'b1;
        end
      end
      S_ERROR: begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        FlushE_o = 1'b1;
      end
      default: begin
        // Pipeline registers have no reset, so INIT keeps bubbles flowing in.
        StallF_o = 1'b1;
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
      end
    endcase
  end

  function automatic logic [1:0] fwd_sel(input logic [ADDR_WIDTH-1:0] rs,
                                         input logic                  wr_m,
                                         input logic [ADDR_WIDTH-1:0] rd_m,
                                         input logic                  wr_w,
                                         input logic [ADDR_WIDTH-1:0] rd_w);
    if (wr_m && (rd_m != '0) && (rd_m == rs))      return 2'b10;
    else if (wr_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
    else                                           return 2'b00;
  endfunction

  always_comb begin
    ForwardAE_o = 2'b00;
    ForwardBE_o = 2'b00;
    if (active) begin
      ForwardAE_o = fwd_sel(Rs1E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
      ForwardBE_o = fwd_sel(Rs2E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
    end
  end

  assign ImemErr_o = (state_q == S_ERROR);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (active && StallF_o && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (active && PCSrcE_i && (flush_count_q != '1))  flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign StallCycles_o = stall_cycles_q;
  assign FlushCount_o  = flush_count_q;
`else
  assign StallCycles_o = '0;
  assign FlushCount_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller; perf-counter expectations follow
// HAZARD_PERF_CNT_EN.
module tb_hazard_controller;

  localparam int AW = 5;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
  logic          ResultSrcE0_i, RegWriteM_i, RegWriteW_i, PCSrcE_i, ImemReady_i;
  logic          StallF_o, StallD_o, FlushD_o, FlushE_o, ImemErr_o;
  logic [1:0]    ForwardAE_o, ForwardBE_o;
  logic [31:0]   StallCycles_o, FlushCount_o;

  int n_asserts = 0;
  int n_fails   = 0;

  hazard_controller #(.ADDR_WIDTH(AW), .RESET_BUBBLES(3), .IMEM_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
    .RdE_i(RdE_i), .RdM_i(RdM_i), .RdW_i(RdW_i),
    .ResultSrcE0_i(ResultSrcE0_i), .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i),
    .PCSrcE_i(PCSrcE_i), .ImemReady_i(ImemReady_i),
    .StallF_o(StallF_o), .StallD_o(StallD_o), .FlushD_o(FlushD_o), .FlushE_o(FlushE_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o), .ImemErr_o(ImemErr_o),
    .StallCycles_o(StallCycles_o), .FlushCount_o(FlushCount_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ctrl packs {StallF, StallD, FlushD, FlushE}
  task automatic check_ctrl(input string tag, input logic [3:0] exp);
    check(tag, 32'({StallF_o, StallD_o, FlushD_o, FlushE_o}), 32'(exp));
  endtask

  task automatic check_fwd(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
    check(tag, 32'({ForwardAE_o, ForwardBE_o}), 32'({exp_a, exp_b}));
  endtask

  task automatic idle();
    Rs1D_i = '0; Rs2D_i = '0; Rs1E_i = '0; Rs2E_i = '0;
    RdE_i = '0; RdM_i = '0; RdW_i = '0;
    ResultSrcE0_i = 1'b0; RegWriteM_i = 1'b0; RegWriteW_i = 1'b0;
    PCSrcE_i = 1'b0; ImemReady_i = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    settle();
    check_ctrl("reset_ctrl", 4'b1011);
    check_fwd("reset_fwd", 2'b00, 2'b00);
    check("reset_err", 32'(ImemErr_o), 32'd0);
    tick(); tick();

    // Reset release: exactly three bubble cycles
    rst_n = 1'b1;
    settle();
    check_ctrl("init_0", 4'b1011);
    tick(); settle(); check_ctrl("init_1", 4'b1011);
    tick(); settle(); check_ctrl("init_2", 4'b1011);
    tick(); settle(); check_ctrl("run_idle", 4'b0000);
    check("run_err", 32'(ImemErr_o), 32'd0);

    // Load-use on Rs1D
    tick(); ResultSrcE0_i = 1'b1; RdE_i = 5'd5; Rs1D_i = 5'd5; settle();
    check_ctrl("load_use_rs1", 4'b1101);
    tick(); idle(); settle();
    check_ctrl("load_use_gone", 4'b0000);
    // RdE = x0 never stalls
    tick(); ResultSrcE0_i = 1'b1; RdE_i = 5'd0; Rs1D_i = 5'd0; settle();
    check_ctrl("load_use_x0", 4'b0000);
    // Load-use on Rs2D
    tick(); idle(); ResultSrcE0_i = 1'b1; RdE_i = 5'd9; Rs2D_i = 5'd9; settle();
    check_ctrl("load_use_rs2", 4'b1101);
    // Non-load producer does not stall
    tick(); ResultSrcE0_i = 1'b0; settle();
    check_ctrl("no_load", 4'b0000);
    // Branch overrides load-use
    tick(); PCSrcE_i = 1'b1; ResultSrcE0_i = 1'b1; RdE_i = 5'd7; Rs2D_i = 5'd7; settle();
    check_ctrl("branch_over_load", 4'b0011);
    // Branch overrides imem wait
    tick(); idle(); PCSrcE_i = 1'b1; ImemReady_i = 1'b0; settle();
    check_ctrl("branch_over_imem", 4'b0011);

    // Forwarding
    tick(); idle(); RegWriteM_i = 1'b1; RdM_i = 5'd3; RegWriteW_i = 1'b1; RdW_i = 5'd3;
    Rs1E_i = 5'd3; settle();
    check_fwd("fwd_m_prio", 2'b10, 2'b00);
    RdM_i = 5'd4; settle();
    check_fwd("fwd_w", 2'b01, 2'b00);
    Rs1E_i = 5'd0; settle();
    check_fwd("fwd_x0", 2'b00, 2'b00);
    Rs1E_i = 5'd3; Rs2E_i = 5'd4; settle();
    check_fwd("fwd_a_w_b_m", 2'b01, 2'b10);
    RegWriteM_i = 1'b0; RdW_i = 5'd4; settle();
    check_fwd("fwd_m_disabled", 2'b00, 2'b01);
    RegWriteW_i = 1'b0; settle();
    check_fwd("fwd_none", 2'b00, 2'b00);

    // Imem wait: 5 low cycles, then ready
    tick(); idle(); ImemReady_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_ctrl($sformatf("iwait5_%0d", i), 4'b1010);
      tick();
    end
    ImemReady_i = 1'b1; settle();
    check_ctrl("iwait5_ready", 4'b0000);
    check("iwait5_err", 32'(ImemErr_o), 32'd0);
    // Load-use beats imem wait while in IWAIT
    tick(); ImemReady_i = 1'b0; tick();
    ResultSrcE0_i = 1'b1; RdE_i = 5'd2; Rs1D_i = 5'd2; settle();
    check_ctrl("iwait_load_prio", 4'b1101);
    tick(); idle(); settle();
    check_ctrl("iwait_exit", 4'b0000);

    // Branch inside IWAIT restarts the watchdog
    tick(); ImemReady_i = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    PCSrcE_i = 1'b1; settle();
    check_ctrl("iwait_branch", 4'b0011);
    tick(); PCSrcE_i = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    settle();
    check("restart_no_err", 32'(ImemErr_o), 32'd0);
    check_ctrl("restart_still_wait", 4'b1010);
    ImemReady_i = 1'b1; settle();
    check_ctrl("restart_ready", 4'b0000);

    // Watchdog: 64 consecutive low cycles from RUN
    tick(); tick(); ImemReady_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) begin
        settle();
        check("timeout_last_wait", 32'(ImemErr_o), 32'd0);
      end
      tick();
    end
    settle();
    check("timeout_err", 32'(ImemErr_o), 32'd1);
    check_ctrl("error_ctrl", 4'b1101);
    // ERROR ignores every input
    ImemReady_i = 1'b1; PCSrcE_i = 1'b1; RegWriteM_i = 1'b1; RdM_i = 5'd6; Rs1E_i = 5'd6;
    for (int i = 0; i < 3; i++) tick();
    settle();
    check("error_sticky", 32'(ImemErr_o), 32'd1);
    check_ctrl("error_ctrl_hold", 4'b1101);
    check_fwd("error_fwd", 2'b00, 2'b00);

    // Asynchronous reset mid-error, with noisy inputs during INIT
    #2 rst_n = 1'b0;
    ResultSrcE0_i = 1'b1; RdE_i = 5'd5; Rs1D_i = 5'd5; ImemReady_i = 1'b0;
    settle();
    check("rst_clears_err", 32'(ImemErr_o), 32'd0);
    check_ctrl("rst_ctrl", 4'b1011);
    check_fwd("rst_fwd", 2'b00, 2'b00);
    tick(); rst_n = 1'b1; settle();
    check_ctrl("init2_0", 4'b1011);
    check_fwd("init2_fwd", 2'b00, 2'b00);
    tick(); settle(); check_ctrl("init2_1", 4'b1011);
    tick(); settle(); check_ctrl("init2_2", 4'b1011);
    idle();
    tick(); settle(); check_ctrl("run2_idle", 4'b0000);
    check("perf_stall_init", StallCycles_o, 32'd0);
    check("perf_flush_init", FlushCount_o, 32'd0);

    // Perf: 2 load-use + 3 imem-wait stall cycles, 2 taken branches
    ResultSrcE0_i = 1'b1; RdE_i = 5'd8; Rs1D_i = 5'd8;
    tick(); tick(); idle(); ImemReady_i = 1'b0;
    tick(); tick(); tick(); ImemReady_i = 1'b1; PCSrcE_i = 1'b1; settle();
    check_ctrl("perf_branch_iwait", 4'b0011);
    tick(); idle(); tick(); PCSrcE_i = 1'b1;
    tick(); idle(); settle();
    check("perf_stall", StallCycles_o, PERF ? 32'd5 : 32'd0);
    check("perf_flush", FlushCount_o, PERF ? 32'd2 : 32'd0);
    check_ctrl("perf_idle", 4'b0000);
    #2 rst_n = 1'b0;
    settle();
    check("perf_stall_rst", StallCycles_o, 32'd0);
    check("perf_flush_rst", FlushCount_o, 32'd0);
    tick(); rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central stall/flush/forward controller for the 5-stage pipeline.
- Drives enable/clear controls for the fetch PC register and the F/D and D/E pipeline registers.
- Sequences a post-reset bubble period, because the pipeline registers have no reset.
- Handles load-use stalls, taken-branch flushes, instruction-memory wait states with a watchdog, and E-stage operand forwarding.
- Clocked on posedge clk. Outputs settle before the pipeline registers capture on negedge clk.

Parameters:
- ADDR_WIDTH, 5: register index width.
- RESET_BUBBLES, 3: cycles in INIT after reset release (1..15).
- IMEM_TIMEOUT, 64: consecutive not-ready cycles before ERROR (2..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- Rs1D_i, Rs2D_i  in  ADDR_WIDTH  source registers in D.
- Rs1E_i, Rs2E_i  in  ADDR_WIDTH  source registers in E.
- RdE_i, RdM_i, RdW_i  in  ADDR_WIDTH  destination registers in E/M/W.
- ResultSrcE0_i  in  1  instruction in E is a load.
- RegWriteM_i, RegWriteW_i  in  1  register write enables in M/W.
- PCSrcE_i  in  1  branch/jump taken, resolved in E.
- ImemReady_i  in  1  instruction for current PC is valid this cycle.
- StallF_o  out  1  hold PC.
- StallD_o  out  1  hold F/D register.
- FlushD_o  out  1  load bubble into F/D.
- FlushE_o  out  1  load bubble into D/E.
- ForwardAE_o, ForwardBE_o  out  2  00 = regfile, 10 = M result, 01 = W result.
- ImemErr_o  out  1  sticky watchdog error.
- StallCycles_o, FlushCount_o  out  32  performance counters (see Optional Feature).

Behaviour:
- FSM states: INIT, RUN, IWAIT, ERROR.
- Reset (asynchronous, any time, including mid-wait or mid-error):
  - state = INIT, bubble counter = 0, wait counter = 0, ImemErr_o = 0.
  - Outputs during reset and INIT: StallF_o = 1, StallD_o = 0, FlushD_o = 1, FlushE_o = 1, ForwardAE_o/ForwardBE_o = 00.
- INIT:
  - Bubble counter increments each cycle.
  - After exactly RESET_BUBBLES cycles following rst_n deassertion, go to RUN.
  - All inputs are ignored in INIT.
- RUN/IWAIT control outputs, evaluated combinationally with fixed priority:
  1. PCSrcE_i=1: StallF=0, StallD=0, FlushD=1, FlushE=1. Overrides load-use and imem wait; the PC must take the target.
  2. Load-use: ResultSrcE0_i=1 and RdE_i≠0 and (RdE_i==Rs1D_i or RdE_i==Rs2D_i). Drives StallF=1, StallD=1, FlushE=1, FlushD=0.
  3. ImemReady_i=0: StallF=1, StallD=0, FlushD=1, FlushE=0.
  4. Otherwise all four outputs are 0.
- Forwarding, combinational in RUN and IWAIT only; otherwise 00. Same rule for B using Rs2E_i.
  - ForwardAE = 10 if RegWriteM_i and RdM_i≠0 and RdM_i==Rs1E_i.
  - Else 01 if RegWriteW_i and RdW_i≠0 and RdW_i==Rs1E_i.
  - Else 00. M takes priority over W.
- State transitions (posedge):
  - RUN → IWAIT when ImemReady_i=0 and PCSrcE_i=0. Wait counter := 1.
  - IWAIT, ImemReady_i=1 → RUN. Counter := 0.
  - IWAIT, ImemReady_i=0 → counter increments. When counter == IMEM_TIMEOUT, go to ERROR.
  - IWAIT, PCSrcE_i=1 → counter := 0. State stays IWAIT if ImemReady_i=0 (new fetch), else goes to RUN.
- ERROR:
  - StallF=1, StallD=1, FlushD=0, FlushE=1, forwarding 00, ImemErr_o=1.
  - Exits only via reset.
- Wait counter: 8-bit, never wraps (bounded by IMEM_TIMEOUT ≤ 255).

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - StallCycles_o increments each RUN/IWAIT cycle with StallF_o=1.
  - FlushCount_o increments each cycle with PCSrcE_i=1 in RUN/IWAIT.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Not defined: both ports tied to 0 and no counter flops are inferred.

Test Plan:
- Reset release with RESET_BUBBLES=3, all inputs idle: StallF/FlushD/FlushE are 1 for exactly 3 posedges, then all 0.
- Load-use: ResultSrcE0=1, RdE=5, Rs1D=5: StallF=StallD=FlushE=1 for one cycle. The same pattern with RdE=0 produces no stall.
- Branch plus load-use in the same cycle (PCSrcE=1, RdE=Rs2D=7, load): StallF=0, StallD=0, FlushD=1, FlushE=1.
- Forwarding: RegWriteM=1, RdM=3, RegWriteW=1, RdW=3, Rs1E=3 gives ForwardAE=10. RdM=4 gives 01. Rs1E=0 gives 00.
- ImemReady low for 5 cycles then high: StallF=1, FlushD=1 for 5 cycles, state returns to RUN, ImemErr_o=0. Low for 64 cycles: ImemErr_o=1 from the next cycle, and it persists until rst_n pulse.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls plus 3 imem-wait cycles give StallCycles_o=5. Two taken branches give FlushCount_o=2. Asynchronous reset mid-count returns both to 0.
